result_to_digits: RTL
=====================

// Module: result_to_digits
// PURPOSE
//  Converts the 14-bit binary calculator result into four 6-bit display codes (thousands..ones)
//  for the seven-segment driver; the inverse of the digit-to-binary path in the math unit.
//  Sequential double-dabble converter with start/busy/done handshake and sign handling.
//  Output codes: 0-9 digits, 10 blank, 15 minus, 16 'E'.
// PARAMETERS
//  IN_W          14  width of the binary result input
//  BLANK_LEADING 1   1 = leading zeros shown as blank (10); 0 = shown as 0
// PORTS
//  clk         in   1     single system clock, rising edge
//  reset_n     in   1     asynchronous, active-low reset
//  start       in   1     request conversion of total; honoured only in IDLE
//  signed_mode in   1     1 = total is two's complement (subtract result), 0 = unsigned
//  total       in   IN_W  binary result from math unit
//  busy        out  1     high while a conversion is in progress
//  done        out  1     one-cycle pulse when the digit outputs have updated
//  err         out  1     result not displayable; held until next done
//  dig3..dig0  out  6     display codes, dig3 = thousands/sign, dig0 = ones
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE, busy=0, done=0, err=0, dig3..dig0=10.
//  FSM IDLE -> PREP -> SHIFT -> FORMAT -> IDLE.
//   IDLE:   start=1 latches total and signed_mode; go PREP. Inputs are ignored thereafter.
//   PREP:   neg = signed_mode & total[13]; mag = neg ? -total : total (IN_W bits).
//           ovf = (!neg & mag>9999) | (neg & mag>999). Load the shift register {16'b0, mag}.
//   SHIFT:  14 cycles, cnt 0..13; each cycle add 3 to every BCD nibble >=5, then shift left 1.
//   FORMAT: build codes, register outputs, pulse done; go IDLE.
//  Latency: done is high in the cycle after the 16th rising edge following the edge that
//   sampled start. Outputs change only on that edge.
//  busy: 1 from the edge after start through FORMAT; 0 in the done cycle.
//  start while busy: ignored, no queueing. start during the done cycle (IDLE): accepted.
//  Formatting:
//   ovf        -> err=1, all digits 16.
//   otherwise  -> err=0, BCD nibbles to codes 0-9. If BLANK_LEADING, zeros above the
//                 most significant nonzero digit become 10; dig0 is never blanked.
//   neg        -> dig3=15 (minus), independent of blanking.
//  Negative zero cannot occur; total=0 with signed_mode gives a non-negative 0.
//  Reset mid-conversion: immediate abort to reset values; no done pulse.
// STRUCTURE
//  calc_pkg (shared): CODE_W=6, DIGIT_BLANK=10, OP_ADD=11, OP_SUB=12, OP_MUL=13, OP_DIV=14,
//   DIGIT_MINUS=15, DIGIT_ERR=16, state_t enum {IDLE,PREP,SHIFT,FORMAT}.
//  Sub-module bcd_add3: 4-bit combinational nibble corrector (>=5 -> +3), instantiated
//   4 times. FSM, counter and shift register live in result_to_digits.
// TESTING
//  1 unsigned total=9801 -> 9,8,0,1; err=0; done exactly 16 edges after start; busy low.
//  2 unsigned total=7, BLANK_LEADING=1 -> 10,10,10,7; BLANK_LEADING=0 -> 0,0,0,7.
//  3 signed total=14'h3FF9 (-7) -> 15,10,10,7; signed total=-99 -> 15,10,9,9.
//  4 unsigned total=12000 -> err=1, all digits 16; signed -1000 -> err=1.
//  5 total=0, either mode -> 10,10,10,0; then total=5 -> err clears, 10,10,10,5.
//  6 reset_n low at edge 8 of a conversion -> busy=0, digits=10, no done;
//    start pulsed while busy -> ignored, only one done.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator definitions: display code values, operator codes and the
// state type of the result-to-digits converter.
package calc_pkg;

    localparam int CODE_W = 6;

    localparam logic [CODE_W-1:0] DIGIT_BLANK = 6'd10;
    localparam logic [CODE_W-1:0] OP_ADD      = 6'd11;
    localparam logic [CODE_W-1:0] OP_SUB      = 6'd12;
    localparam logic [CODE_W-1:0] OP_MUL      = 6'd13;
    localparam logic [CODE_W-1:0] OP_DIV      = 6'd14;
    localparam logic [CODE_W-1:0] DIGIT_MINUS = 6'd15;
    localparam logic [CODE_W-1:0] DIGIT_ERR   = 6'd16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PREP   = 2'd1,
        SHIFT  = 2'd2,
        FORMAT = 2'd3
    } state_t;

    // A BCD nibble maps directly onto the digit codes 0-9.
    function automatic logic [CODE_W-1:0] nib_to_code(input logic [3:0] nib);
        return {{(CODE_W-4){1'b0}}, nib};
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble corrector: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3 (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    // Correct the nibble before it is doubled by the shift.
    assign o_nib = (i_nib >= 4'd5) ? i_nib + 4'd3 : i_nib;

endmodule

// File: rtl/result_to_digits.sv
// Sequential binary-to-display converter. Takes the calculator result,
// resolves sign and range, runs a double-dabble over the magnitude and
// registers four display codes (dig3 = thousands / sign, dig0 = ones).
module result_to_digits
    import calc_pkg::*;
#(
    parameter int IN_W          = 14,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              signed_mode,
    input  logic [IN_W-1:0]   total,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CODE_W-1:0] dig3,
    output logic [CODE_W-1:0] dig2,
    output logic [CODE_W-1:0] dig1,
    output logic [CODE_W-1:0] dig0
);

    localparam int              SH_W  = 16 + IN_W;
    localparam int              CNT_W = $clog2(IN_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(IN_W - 1);

    state_t                        r_state, w_next;
    logic [IN_W-1:0]               r_total;
    logic                          r_signed;
    logic                          r_neg, r_ovf;
    logic [SH_W-1:0]               r_sh;
    logic [CNT_W-1:0]              r_cnt;
    logic                          r_done, r_err;
    logic [3:0][CODE_W-1:0]        r_dig;

    logic                          w_neg, w_ovf;
    logic [IN_W-1:0]               w_mag;
    logic [3:0][3:0]               w_corr;
    logic [3:0][3:0]               w_bcd;
    logic [SH_W-1:0]               w_adj;
    logic [3:0][CODE_W-1:0]        w_code;
    logic                          w_busy, w_cap, w_load, w_shift, w_fmt;

    // Sign and range of the latched operand; only consumed in PREP.
    always_comb begin
        w_neg = r_signed & r_total[IN_W-1];
        w_mag = w_neg ? ({IN_W{1'b0}} - r_total) : r_total;
        w_ovf = w_neg ? (w_mag > IN_W'(999)) : (w_mag > IN_W'(9999));
    end

    // One corrector per BCD digit of the shift register.
    for (genvar g = 0; g < 4; g++) begin : g_add3
        bcd_add3 u_add3 (
            .i_nib (r_sh[IN_W + 4*g +: 4]),
            .o_nib (w_corr[g])
        );
    end

    assign w_adj = {w_corr, r_sh[IN_W-1:0]};
    assign w_bcd = r_sh[SH_W-1 -: 16];

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Next-state: fixed walk through the phases; start only matters in IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = PREP;
            PREP:    w_next = SHIFT;
            SHIFT:   if (r_cnt == LAST) w_next = FORMAT;
            FORMAT:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Per-state control strobes.
    always_comb begin
        w_busy  = (r_state != IDLE);
        w_cap   = (r_state == IDLE) & start;
        w_load  = (r_state == PREP);
        w_shift = (r_state == SHIFT);
        w_fmt   = (r_state == FORMAT);
    end

    // Digit codes from the final BCD value, with blanking, sign and error.
    always_comb begin
        for (int i = 0; i < 4; i++) w_code[i] = nib_to_code(w_bcd[i]);
        if (BLANK_LEADING) begin
            if (w_bcd[3] == 4'd0)                                         w_code[3] = DIGIT_BLANK;
            if (w_bcd[3] == 4'd0 && w_bcd[2] == 4'd0)                     w_code[2] = DIGIT_BLANK;
            if (w_bcd[3] == 4'd0 && w_bcd[2] == 4'd0 && w_bcd[1] == 4'd0) w_code[1] = DIGIT_BLANK;
        end
        if (r_neg) w_code[3] = DIGIT_MINUS;
        if (r_ovf) begin
            for (int i = 0; i < 4; i++) w_code[i] = DIGIT_ERR;
        end
    end

    // Operand capture, magnitude load and the shift/correct iterations.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_total  <= '0;
            r_signed <= 1'b0;
            r_neg    <= 1'b0;
            r_ovf    <= 1'b0;
            r_sh     <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_cap) begin
                r_total  <= total;
                r_signed <= signed_mode;
            end
            if (w_load) begin
                r_neg <= w_neg;
                r_ovf <= w_ovf;
                r_sh  <= {16'b0, w_mag};
                r_cnt <= '0;
            end
            if (w_shift) begin
                r_sh  <= {w_adj[SH_W-2:0], 1'b0};
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Display outputs update only at the end of FORMAT, with a one-cycle done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_dig  <= {4{DIGIT_BLANK}};
        end else begin
            r_done <= w_fmt;
            if (w_fmt) begin
                r_err <= r_ovf;
                r_dig <= w_code;
            end
        end
    end

    assign busy = w_busy;
    assign done = r_done;
    assign err  = r_err;
    assign dig3 = r_dig[3];
    assign dig2 = r_dig[2];
    assign dig1 = r_dig[1];
    assign dig0 = r_dig[0];

endmodule
